// File: rtl/isp_tpg_defect.sv
// Raster test-pattern source with reproducible LFSR-driven hot/dead pixel injection.
// Optional `TPG_DEFECT_LOG_EN adds defect_flag/defect_cnt observation ports.
module isp_tpg_defect #(
    parameter int          H        = 720,
    parameter int          V        = 480,
    parameter int          BLANK    = 16,
    parameter int          DEF_BITS = 6,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        tpg_en,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    input  logic        defect_en,
    input  logic        pixel_ready,
    output logic        pixel_valid,
    output logic [23:0] pixel_data_out,
    output logic        sof,
    output logic        eol,
    output logic        eof,
    output logic        busy,
    output logic        frame_done
`ifdef TPG_DEFECT_LOG_EN
    ,
    output logic        defect_flag,
    output logic [15:0] defect_cnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_DONE} state_t;

    localparam logic [15:0] X_LAST   = 16'(H - 1);
    localparam logic [15:0] Y_LAST   = 16'(V - 1);
    localparam logic [15:0] X_HI     = 16'(H - 3);
    localparam logic [15:0] Y_HI     = 16'(V - 3);
    localparam logic [15:0] BAR_LAST = 16'(H / 8 - 1);
    localparam logic [15:0] BLANK_LD = 16'(BLANK - 1);

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  bar_q, bar_d;
    logic [15:0] bar_cnt_q, bar_cnt_d;
    logic [15:0] blank_q, blank_d;
    logic [1:0]  pat_q, pat_d;
    logic        def_q, def_d;
    logic [15:0] lfsr_adv;
    logic        inject;
    logic [23:0] base_rgb, pix;
    logic [7:0]  c;

    assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            lfsr_q    <= SEED;
            bar_q     <= '0;
            bar_cnt_q <= '0;
            blank_q   <= '0;
            pat_q     <= '0;
            def_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lfsr_q    <= lfsr_d;
            bar_q     <= bar_d;
            bar_cnt_q <= bar_cnt_d;
            blank_q   <= blank_d;
            pat_q     <= pat_d;
            def_q     <= def_d;
        end
    end

    // Everything holds while a beat is offered but not taken; that is the freeze rule.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        lfsr_d    = lfsr_q;
        bar_d     = bar_q;
        bar_cnt_d = bar_cnt_q;
        blank_d   = blank_q;
        pat_d     = pat_q;
        def_d     = def_q;
        case (state_q)
            S_IDLE: begin
                if (start && tpg_en) begin
                    state_d   = S_ACTIVE;
                    x_d       = '0;
                    y_d       = '0;
                    lfsr_d    = SEED;
                    bar_d     = '0;
                    bar_cnt_d = '0;
                    pat_d     = pattern_sel;
                    def_d     = defect_en;
                end
            end
            S_ACTIVE: begin
                if (pixel_ready) begin
                    lfsr_d = lfsr_adv;
                    if (bar_cnt_q == BAR_LAST) begin
                        bar_cnt_d = '0;
                        bar_d     = bar_q + 3'd1;
                    end else begin
                        bar_cnt_d = bar_cnt_q + 16'd1;
                    end
                    if (x_q != X_LAST) begin
                        x_d = x_q + 16'd1;
                    end else begin
                        x_d = '0;
                        if (y_q != Y_LAST) begin
                            y_d     = y_q + 16'd1;
                            blank_d = BLANK_LD;
                            state_d = S_HBLANK;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (blank_q == '0) state_d = S_ACTIVE;
                else               blank_d = blank_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (!tpg_en) state_d = S_IDLE;
    end

    // Border exclusion keeps defects where a 5x5 corrector window fits fully.
    assign inject = def_q && (lfsr_q[DEF_BITS-1:0] == '0) &&
                    (x_q >= 16'd2) && (x_q <= X_HI) && (y_q >= 16'd2) && (y_q <= Y_HI);

    always_comb begin
        c        = 8'h80;
        base_rgb = {3{8'h80}};
        case (pat_q)
            2'd1: begin
                c        = x_q[7:0];
                base_rgb = {3{c}};
            end
            2'd2: begin
                c        = (x_q[3] ^ y_q[3]) ? 8'hC0 : 8'h40;
                base_rgb = {3{c}};
            end
            2'd3: base_rgb = {bar_q[2] ? 8'hC0 : 8'h00,
                              bar_q[1] ? 8'hC0 : 8'h00,
                              bar_q[0] ? 8'hC0 : 8'h00};
            default: base_rgb = {3{c}};
        endcase
        pix = inject ? (lfsr_q[15] ? 24'hFFFFFF : 24'h000000) : base_rgb;
    end

    always_comb begin
        pixel_valid    = (state_q == S_ACTIVE);
        pixel_data_out = pixel_valid ? pix : 24'h0;
        sof            = pixel_valid && (x_q == '0) && (y_q == '0);
        eol            = pixel_valid && (x_q == X_LAST);
        eof            = pixel_valid && (x_q == X_LAST) && (y_q == Y_LAST);
        busy           = (state_q == S_ACTIVE) || (state_q == S_HBLANK);
        frame_done     = (state_q == S_DONE);
    end

`ifdef TPG_DEFECT_LOG_EN
    logic [15:0] defect_cnt_q, defect_cnt_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) defect_cnt_q <= '0;
        else       defect_cnt_q <= defect_cnt_d;
    end

    always_comb begin
        defect_cnt_d = defect_cnt_q;
        if (state_q == S_IDLE && start && tpg_en)
            defect_cnt_d = '0;
        else if (pixel_valid && pixel_ready && inject && defect_cnt_q != 16'hFFFF)
            defect_cnt_d = defect_cnt_q + 16'd1;
    end

    assign defect_flag = pixel_valid && inject;
    assign defect_cnt  = defect_cnt_q;
`endif

endmodule

// File: tb/tb_isp_tpg_defect.sv
// Bench for isp_tpg_defect: raster reference model fed by randomized handshake stimulus.
module tb_isp_tpg_defect;
    localparam int          H        = 16;
    localparam int          V        = 12;
    localparam int          BLANK    = 3;
    localparam int          DEF_BITS = 1;
    localparam logic [15:0] SEED     = 16'hACE1;
`ifdef TPG_DEFECT_LOG_EN
    localparam logic [27:0] CMP_MASK = 28'hFFFFFFF;
`else
    localparam logic [27:0] CMP_MASK = 28'hFFFFFFE;
`endif

    logic        clk = 0, rstn = 0, tpg_en = 0, start = 0, defect_en = 0, pixel_ready = 0;
    logic [1:0]  pattern_sel = 0;
    logic        pixel_valid, sof, eol, eof, busy, frame_done;
    logic [23:0] pixel_data_out;
`ifdef TPG_DEFECT_LOG_EN
    logic        defect_flag;
    logic [15:0] defect_cnt;
`endif

    int          compares = 0, fails = 0;
    logic [27:0] obs_d[$], exp_d[$];
    int          obs_c[$];
    int          fd_cyc, exp_ndef;

    isp_tpg_defect #(.H(H), .V(V), .BLANK(BLANK), .DEF_BITS(DEF_BITS), .SEED(SEED)) dut (
        .clk(clk), .rstn(rstn), .tpg_en(tpg_en), .start(start), .pattern_sel(pattern_sel),
        .defect_en(defect_en), .pixel_ready(pixel_ready), .pixel_valid(pixel_valid),
        .pixel_data_out(pixel_data_out), .sof(sof), .eol(eol), .eof(eof), .busy(busy),
        .frame_done(frame_done)
`ifdef TPG_DEFECT_LOG_EN
        , .defect_flag(defect_flag), .defect_cnt(defect_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference raster: {rgb, sof, eol, eof, defect} per pixel in scan order.
    function automatic void build_model(input logic [1:0] pat, input logic de);
        int unsigned l, b, fb;
        logic [23:0] rgb;
        logic        inj;
        l = SEED;
        exp_d.delete();
        exp_ndef = 0;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                case (pat)
                    2'd0: rgb = 24'h808080;
                    2'd1: rgb = {3{8'(x % 256)}};
                    2'd2: rgb = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? 24'hC0C0C0 : 24'h404040;
                    default: begin
                        b   = x / (H / 8);
                        rgb = {((b & 4) != 0) ? 8'hC0 : 8'h00, ((b & 2) != 0) ? 8'hC0 : 8'h00,
                               ((b & 1) != 0) ? 8'hC0 : 8'h00};
                    end
                endcase
                inj = de && ((l % (1 << DEF_BITS)) == 0) && x >= 2 && x < H - 2 && y >= 2 && y < V - 2;
                if (inj) begin
                    rgb = ((l >> 15) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
                    exp_ndef++;
                end
                exp_d.push_back({rgb, x == 0 && y == 0, x == H - 1, x == H - 1 && y == V - 1, inj});
                fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
                l  = ((l << 1) | fb) & 16'hFFFF;
            end
        end
    endfunction

    // rmode: 0 always ready, 1 random ready, 2 stall 3 cycles at x=3,y=1
    task automatic run_frame(input logic [1:0] pat, input logic de, input int rmode,
                             input int mid_start, input int abort_at);
        int          cyc, n, stall;
        logic        hold, bad;
        logic [23:0] pd;
        logic [27:0] rec;
        build_model(pat, de);
        obs_d.delete();
        obs_c.delete();
        fd_cyc = -1;
        @(negedge clk);
        pattern_sel = pat; defect_en = de; start = 1;
        @(negedge clk);
        start = 0; pattern_sel = ~pat; defect_en = ~de;
`ifdef TPG_DEFECT_LOG_EN
        compares++;
        if (defect_cnt !== 16'h0) begin
            fails++; $display("FAIL defect_cnt_clear: got %0d want 0", defect_cnt);
        end
`endif
        cyc = 0; n = 0; stall = 3; hold = 0; pd = '0;
        while (fd_cyc < 0 && cyc < 4000) begin
            if (hold) begin
                compares++;
                if (pixel_valid !== 1'b1 || pixel_data_out !== pd) begin
                    fails++; $display("FAIL hold cyc %0d: got v=%b %h want v=1 %h", cyc, pixel_valid, pixel_data_out, pd);
                end
            end
            if (pixel_valid && !busy) begin
                compares++; fails++; $display("FAIL busy cyc %0d: got 0 want 1", cyc);
            end
            if (abort_at >= 0 && n == abort_at && pixel_valid) begin
                tpg_en = 0; pixel_ready = 0;
                @(negedge clk);
                compares++;
                if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
                    fails++; $display("FAIL abort: got v=%b busy=%b want 0 0", pixel_valid, busy);
                end
                bad = 0;
                repeat (20) begin
                    @(negedge clk);
                    if (frame_done !== 1'b0 || pixel_valid !== 1'b0) bad = 1;
                end
                compares++;
                if (bad) begin fails++; $display("FAIL abort_quiet: got activity want none"); end
                tpg_en = 1;
                return;
            end
            case (rmode)
                0: pixel_ready = 1;
                1: pixel_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    pixel_ready = 1;
                    if (n == H + 3 && stall > 0 && pixel_valid) begin
                        pixel_ready = 0;
                        stall--;
                        compares++;
                        if (pixel_data_out !== 24'h030303 || eol !== 1'b0) begin
                            fails++; $display("FAIL stall: got %h eol=%b want 030303 eol=0", pixel_data_out, eol);
                        end
                    end
                end
            endcase
            start = (cyc == mid_start);
            if (pixel_valid && pixel_ready) begin
                rec = {pixel_data_out, sof, eol, eof, 1'b0};
`ifdef TPG_DEFECT_LOG_EN
                rec[0] = defect_flag;
`endif
                obs_d.push_back(rec);
                obs_c.push_back(cyc);
                n++;
            end
            if (frame_done) begin
                fd_cyc = cyc;
`ifdef TPG_DEFECT_LOG_EN
                compares++;
                if (defect_cnt !== 16'(exp_ndef)) begin
                    fails++; $display("FAIL defect_cnt: got %0d want %0d", defect_cnt, exp_ndef);
                end
`endif
            end
            hold = pixel_valid && !pixel_ready;
            pd   = pixel_data_out;
            @(negedge clk);
            cyc++;
        end
        start = 0; pixel_ready = 0;
        compares++;
        if (fd_cyc < 0) begin
            fails++; $display("FAIL timeout: got no frame_done want frame_done");
        end else if (frame_done !== 1'b0 || pixel_valid !== 1'b0) begin
            fails++; $display("FAIL done_pulse: got fd=%b v=%b want 0 0", frame_done, pixel_valid);
        end
    endtask

    task automatic check_frame(input string name, input int exp_n, input bit timing);
        int nf = 0;
        compares++;
        if (obs_d.size() != exp_n) begin
            fails++; $display("FAIL %s beats: got %0d want %0d", name, obs_d.size(), exp_n);
        end
        for (int i = 0; i < obs_d.size() && i < exp_n; i++) begin
            compares++;
            if ((obs_d[i] & CMP_MASK) !== (exp_d[i] & CMP_MASK)) begin
                fails++; nf++;
                if (nf <= 5) $display("FAIL %s beat %0d: got %h want %h", name, i, obs_d[i], exp_d[i]);
            end
        end
        if (exp_n == H * V && obs_d.size() == exp_n) begin
            compares++;
            if (fd_cyc != obs_c[exp_n-1] + 1) begin
                fails++; $display("FAIL %s frame_done cyc: got %0d want %0d", name, fd_cyc, obs_c[exp_n-1] + 1);
            end
            if (timing) begin
                compares++;
                if (obs_c[0] != 0) begin fails++; $display("FAIL %s latency: got %0d want 0", name, obs_c[0]); end
                for (int yy = 0; yy < V - 1; yy++) begin
                    compares++;
                    if (obs_c[yy*H+H] - obs_c[yy*H+H-1] != BLANK + 1) begin
                        fails++; $display("FAIL %s gap line %0d: got %0d want %0d", name, yy,
                                          obs_c[yy*H+H] - obs_c[yy*H+H-1], BLANK + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        compares++;
        if ({pixel_valid, pixel_data_out, sof, eol, eof, busy, frame_done} !== '0) begin
            fails++; $display("FAIL reset_outputs: got nonzero want 0");
        end
        @(negedge clk); rstn = 1; tpg_en = 1;
        repeat (4) @(negedge clk);
        compares++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_idle: got v=%b busy=%b want 0 0", pixel_valid, busy);
        end
    endtask

    task automatic test_ramp();
        run_frame(2'd1, 1'b0, 0, -1, -1);
        check_frame("ramp", H * V, 1);
    endtask

    task automatic test_stall();
        run_frame(2'd1, 1'b0, 2, -1, -1);
        check_frame("stall", H * V, 1);
    endtask

    task automatic test_patterns();
        for (int p = 0; p < 4; p++) begin
            run_frame(2'(p), 1'b0, 1, -1, -1);
            check_frame($sformatf("pat%0d", p), H * V, 0);
        end
    endtask

    task automatic test_defect();
        int x, y;
        logic [23:0] d;
        run_frame(2'd0, 1'b1, 1, -1, -1);
        check_frame("defect", H * V, 0);
        for (int i = 0; i < obs_d.size(); i++) begin
            x = i % H; y = i / H; d = obs_d[i][27:4];
            compares++;
            if ((x < 2 || x >= H - 2 || y < 2 || y >= V - 2) ? (d !== 24'h808080)
                : !(d === 24'h808080 || d === 24'hFFFFFF || d === 24'h000000)) begin
                fails++; $display("FAIL defect_value x=%0d y=%0d: got %h", x, y, d);
            end
        end
    endtask

    task automatic test_abort_restart();
        run_frame(2'd3, 1'b1, 0, -1, 2 * H + 5);
        check_frame("abort_part", 2 * H + 5, 0);
        run_frame(2'd3, 1'b1, 0, -1, -1);
        check_frame("restart", H * V, 1);
    endtask

    task automatic test_start_ignored();
        run_frame(2'd2, 1'b1, 0, 10, -1);
        check_frame("mid_start", H * V, 1);
    endtask

    task automatic test_reset_midframe();
        @(negedge clk); pattern_sel = 2'd0; start = 1;
        @(negedge clk); start = 0; pixel_ready = 1;
        repeat (30) @(negedge clk);
        rstn = 0;
        #1;
        compares++;
        if ({pixel_valid, pixel_data_out, sof, eol, eof, busy, frame_done} !== '0) begin
            fails++; $display("FAIL reset_mid: got v=%b d=%h busy=%b want 0", pixel_valid, pixel_data_out, busy);
        end
        @(negedge clk); rstn = 1;
        repeat (3) @(negedge clk);
        compares++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle: got v=%b busy=%b want 0 0", pixel_valid, busy);
        end
        pixel_ready = 0;
        run_frame(2'd1, 1'b1, 1, -1, -1);
        check_frame("after_reset", H * V, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] p;
        logic       de;
        for (int k = 0; k < 2; k++) begin
            p  = 2'($urandom_range(0, 3));
            de = 1'($urandom_range(0, 1));
            run_frame(p, de, 1, -1, -1);
            check_frame($sformatf("b2b%0d", k), H * V, 0);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_stall();
        test_patterns();
        test_defect();
        test_abort_restart();
        test_start_ignored();
        test_reset_midframe();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
